sme_query_scheduler: RTL and testbench

Shares one string-matching engine between NREQ pattern requesters. Holds a reference string (up to 32 bytes) and one pattern slot (up to 8 bytes) per requester. Grants requesters round-robin and streams the string and the granted pattern into the engine's `chardata`/`isstring`/`ispattern` interface. Waits for the engine's `valid`, then returns `match`/`match_index` to the granted requester with a one-cycle `done` strobe. Sits between host-side requesters and the matching engine instance.

---
 rtl/sme_query_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sme_query_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_query_scheduler.sv
// sme_query_scheduler
// Shares one string-matching engine between NREQ pattern requesters. A
// reference string (up to 32 bytes) and one pattern slot (up to 8 bytes) per
// requester are buffered here. Requesters are granted round-robin. The string
// and then the granted pattern are streamed to the engine, the engine result
// is awaited (bounded by TIMEOUT cycles) and returned with a one-cycle done.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   str_wr/str_clr/str_data, str_ready, str_len   string buffer host side
//   pat_wr/pat_sel/pat_data                        pattern slot host side
//   req[NREQ], done[NREQ]                          level request / done strobe
//   res_match, res_index, res_err                  held result of last service
//   eng_chardata/eng_isstring/eng_ispattern        stream to engine
//   eng_valid/eng_match/eng_match_index            result from engine
module sme_query_scheduler #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            str_wr,
  input  logic            str_clr,
  input  logic [7:0]      str_data,
  output logic            str_ready,
  output logic [5:0]      str_len,
  input  logic            pat_wr,
  input  logic [1:0]      pat_sel,
  input  logic [7:0]      pat_data,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] done,
  output logic            res_match,
  output logic [4:0]      res_index,
  output logic            res_err,
  output logic [7:0]      eng_chardata,
  output logic            eng_isstring,
  output logic            eng_ispattern,
  input  logic            eng_valid,
  input  logic            eng_match,
  input  logic [4:0]      eng_match_index
);

  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
  localparam logic [1:0]    LAST_SLOT = 2'(NREQ - 1);
  localparam logic [2:0]    NREQ_W    = 3'(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_DONE} state_t;
  state_t state, state_d;

  // Slot arrays are sized for the maximum of four slots so a 2-bit pat_sel
  // can index them directly; slots at or above NREQ are never written.
  logic [7:0]    str_buf [32];
  logic [7:0]    pat_buf [4][8];
  logic [3:0]    pat_len [4];
  logic [1:0]    g, rr, gnt, cand;
  logic          gnt_any;
  logic [3:0]    req_pad;
  logic [5:0]    idx;
  logic [TW-1:0] timer;
  logic          str_last, pat_last, idle_err, pat_ok;

  // Round-robin search starting at rr.
  always_comb begin
    req_pad = 4'(req);
    gnt_any = 1'b0;
    gnt     = rr;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = 2'((int'(rr) + i) % NREQ);
      if (!gnt_any && req_pad[cand]) begin
        gnt_any = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign str_last = (idx == str_len - 6'd1);
  assign pat_last = (idx == {2'b00, pat_len[g]} - 6'd1);
  assign idle_err = (str_len == 6'd0) || (pat_len[gnt] == 4'd0);
  assign pat_ok   = pat_wr && ({1'b0, pat_sel} < NREQ_W) &&
                    !((state != S_IDLE) && (pat_sel == g)) && (pat_len[pat_sel] < 4'd8);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and engine/host outputs, decoded from registered state only.
  always_comb begin
    state_d       = state;
    str_ready     = (state == S_IDLE);
    eng_isstring  = 1'b0;
    eng_ispattern = 1'b0;
    eng_chardata  = '0;
    done          = '0;
    case (state)
      S_IDLE:     if (gnt_any) state_d = idle_err ? S_DONE : S_SEND_STR;
      S_SEND_STR: begin
        eng_isstring = 1'b1;
        eng_chardata = str_buf[idx[4:0]];
        if (str_last) state_d = S_SEND_PAT;
      end
      S_SEND_PAT: begin
        eng_ispattern = 1'b1;
        eng_chardata  = pat_buf[g][idx[2:0]];
        if (pat_last) state_d = S_WAIT;
      end
      S_WAIT:     if (eng_valid || (timer == T_LAST)) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        for (int i = 0; i < NREQ; i++) done[i] = (g == 2'(i));
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g         <= '0;
      rr        <= '0;
      idx       <= '0;
      timer     <= '0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (gnt_any) begin
          g   <= gnt;
          idx <= '0;
          if (idle_err) begin
            res_err   <= 1'b1;
            res_match <= 1'b0;
            res_index <= '0;
          end
        end
        S_SEND_STR: idx <= str_last ? 6'd0 : idx + 6'd1;
        S_SEND_PAT: begin
          idx   <= idx + 6'd1;
          timer <= '0;
        end
        S_WAIT: begin
          if (eng_valid) begin
            res_match <= eng_match;
            res_index <= eng_match_index;
            res_err   <= 1'b0;
          end else if (timer == T_LAST) begin
            res_err   <= 1'b1;
            res_match <= 1'b0;
            res_index <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: rr <= (g == LAST_SLOT) ? 2'd0 : g + 2'd1;
        default: ;
      endcase
    end
  end

  // Buffer lengths; the served slot is emptied on the way out of DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      str_len <= '0;
      for (int i = 0; i < 4; i++) pat_len[i] <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (str_clr)                         str_len <= '0;
        else if (str_wr && str_len < 6'd32)  str_len <= str_len + 6'd1;
      end
      if (pat_ok) pat_len[pat_sel] <= pat_len[pat_sel] + 4'd1;
      if (state == S_DONE) pat_len[g] <= '0;
    end
  end

  // Buffer contents carry no reset; lengths alone define validity.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && !str_clr && str_wr && (str_len < 6'd32))
      str_buf[str_len[4:0]] <= str_data;
    if (pat_ok)
      pat_buf[pat_sel][pat_len[pat_sel][2:0]] <= pat_data;
  end

endmodule

// File: tb/tb_sme_query_scheduler.sv
module tb_sme_query_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       str_wr, str_clr;
  logic [7:0] str_data;
  logic       str_ready;
  logic [5:0] str_len;
  logic       pat_wr;
  logic [1:0] pat_sel;
  logic [7:0] pat_data;
  logic [1:0] req;
  logic [1:0] done;
  logic       res_match, res_err;
  logic [4:0] res_index;
  logic [7:0] eng_chardata;
  logic       eng_isstring, eng_ispattern;
  logic       eng_valid, eng_match;
  logic [4:0] eng_match_index;

  int total = 0;
  int bad   = 0;

  // Per-transaction observations gathered by serve().
  int          n_str, n_pat, done_cyc;
  logic [1:0]  done_val;
  logic [31:0] s_pack, p_pack;
  logic        rdy_bad, wait_dirty, found;

  sme_query_scheduler #(.NREQ(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .str_wr(str_wr), .str_clr(str_clr), .str_data(str_data),
    .str_ready(str_ready), .str_len(str_len),
    .pat_wr(pat_wr), .pat_sel(pat_sel), .pat_data(pat_data),
    .req(req), .done(done),
    .res_match(res_match), .res_index(res_index), .res_err(res_err),
    .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
    .eng_valid(eng_valid), .eng_match(eng_match), .eng_match_index(eng_match_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wstr(input logic [7:0] b);
    str_data = b;
    str_wr   = 1'b1;
    tick();
    str_wr   = 1'b0;
  endtask

  task automatic wpat(input logic [1:0] s, input logic [7:0] b);
    pat_sel  = s;
    pat_data = b;
    pat_wr   = 1'b1;
    tick();
    pat_wr   = 1'b0;
  endtask

  // Plays the engine: answers vdly cycles into WAIT (0 = never answers).
  // Cycle c=1 is the cycle after the first edge; returns in the done cycle.
  task automatic serve(input int vdly, input logic vm, input logic [4:0] vi);
    int wcnt;
    wcnt = 0; n_str = 0; n_pat = 0; s_pack = '0; p_pack = '0;
    done_cyc = -1; done_val = '0; rdy_bad = 1'b0; wait_dirty = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      eng_valid = 1'b0;
      if (done != 2'b00) begin
        done_val = done;
        done_cyc = c;
        req      = req & ~done;
        break;
      end
      if (eng_isstring) begin
        n_str++;
        s_pack = {s_pack[23:0], eng_chardata};
        if (str_ready) rdy_bad = 1'b1;
      end else if (eng_ispattern) begin
        n_pat++;
        p_pack = {p_pack[23:0], eng_chardata};
      end else if (n_str != 0) begin
        wcnt++;
        if (eng_chardata != 8'h00) wait_dirty = 1'b1;
        if ((vdly != 0) && (wcnt == vdly)) begin
          eng_valid       = 1'b1;
          eng_match       = vm;
          eng_match_index = vi;
        end
      end
    end
    total++;
    assert (done_cyc > 0) else begin
      bad++;
      $error("FAIL serve_bound: got no done expected done within 300 cycles");
    end
  endtask

  initial begin
    reset = 1'b1; str_wr = 1'b0; str_clr = 1'b0; str_data = '0;
    pat_wr = 1'b0; pat_sel = '0; pat_data = '0; req = '0;
    eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_str_ready", 32'(str_ready), 1);
    chk("rst_str_len", 32'(str_len), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res_match", 32'(res_match), 0);
    chk("rst_res_index", 32'(res_index), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_isstring", 32'(eng_isstring), 0);
    chk("rst_ispattern", 32'(eng_ispattern), 0);
    chk("rst_chardata", 32'(eng_chardata), 0);

    // Basic match: string "abcd", slot0 "bc", engine answers 3 cycles into WAIT.
    wstr("a"); wstr("b"); wstr("c"); wstr("d");
    chk("str_len_4", 32'(str_len), 4);
    wpat(2'd0, "b"); wpat(2'd0, "c");
    req = 2'b01;
    serve(3, 1'b1, 5'd1);
    chk("t1_done", 32'(done_val), 1);
    chk("t1_done_cyc", 32'(done_cyc), 10);
    chk("t1_nstr", 32'(n_str), 4);
    chk("t1_str", s_pack, 32'h61626364);
    chk("t1_npat", 32'(n_pat), 2);
    chk("t1_pat", p_pack, 32'h00006263);
    chk("t1_match", 32'(res_match), 1);
    chk("t1_index", 32'(res_index), 1);
    chk("t1_err", 32'(res_err), 0);
    chk("t1_ready_busy", 32'(rdy_bad), 0);
    chk("t1_wait_char0", 32'(wait_dirty), 0);
    chk("t1_ready_done", 32'(str_ready), 0);

    // Slot0 was emptied by the service: immediate error result.
    tick();
    req = 2'b01;
    serve(0, 1'b0, 5'd0);
    chk("t1b_done", 32'(done_val), 1);
    chk("t1b_done_cyc", 32'(done_cyc), 1);
    chk("t1b_err", 32'(res_err), 1);
    chk("t1b_match", 32'(res_match), 0);
    chk("t1b_nstr", 32'(n_str), 0);
    chk("t1b_str_len", 32'(str_len), 4);

    // Out-of-range slot write ignored; empty slot1 errors without streaming.
    tick();
    wpat(2'd3, 8'h55);
    req = 2'b10;
    serve(0, 1'b0, 5'd0);
    chk("t3_done", 32'(done_val), 2);
    chk("t3_done_cyc", 32'(done_cyc), 1);
    chk("t3_err", 32'(res_err), 1);
    chk("t3_nstr", 32'(n_str), 0);
    chk("t3_npat", 32'(n_pat), 0);

    // Round-robin with both requests held: order 0,1,0.
    tick();
    wpat(2'd0, "x"); wpat(2'd1, "y"); wpat(2'd1, "z");
    req = 2'b11;
    serve(1, 1'b1, 5'd5);
    chk("rr1_done", 32'(done_val), 1);
    chk("rr1_pat", p_pack, 32'h00000078);
    chk("rr1_index", 32'(res_index), 5);
    req[0] = 1'b1;
    serve(2, 1'b0, 5'd7);
    chk("rr2_done", 32'(done_val), 2);
    chk("rr2_pat", p_pack, 32'h0000797a);
    chk("rr2_match", 32'(res_match), 0);
    chk("rr2_index", 32'(res_index), 7);
    wpat(2'd0, "q");
    serve(1, 1'b1, 5'd3);
    chk("rr3_done", 32'(done_val), 1);
    chk("rr3_done_cyc", 32'(done_cyc), 7);
    chk("rr3_pat", p_pack, 32'h00000071);
    chk("rr3_err", 32'(res_err), 0);
    chk("rr3_index", 32'(res_index), 3);

    // Clear wins over write; then timeout with a 3-byte string, 2-byte pattern.
    tick();
    str_clr = 1'b1; str_wr = 1'b1; str_data = "z";
    tick();
    str_clr = 1'b0; str_wr = 1'b0;
    chk("clr_wins", 32'(str_len), 0);
    wstr("x"); wstr("y"); wstr("z");
    wpat(2'd0, "y"); wpat(2'd0, "z");
    req = 2'b01;
    serve(0, 1'b0, 5'd0);
    chk("to_done", 32'(done_val), 1);
    chk("to_done_cyc", 32'(done_cyc), 70);
    chk("to_err", 32'(res_err), 1);
    chk("to_match", 32'(res_match), 0);
    chk("to_index", 32'(res_index), 0);
    chk("to_str", s_pack, 32'h0078797a);
    chk("to_npat", 32'(n_pat), 2);
    str_wr = 1'b1; str_data = "k";
    tick();
    str_wr = 1'b0;
    chk("wr_ignored_busy", 32'(str_len), 3);

    // Capacity saturation: 40 string bytes, 10 pattern bytes.
    str_clr = 1'b1;
    tick();
    str_clr = 1'b0;
    for (int i = 0; i < 40; i++) wstr(8'(i + 1));
    chk("str_sat", 32'(str_len), 32);
    for (int i = 0; i < 10; i++) wpat(2'd1, 8'(8'h80 + i));
    req = 2'b10;
    serve(2, 1'b1, 5'd31);
    chk("sat_done", 32'(done_val), 2);
    chk("sat_nstr", 32'(n_str), 32);
    chk("sat_npat", 32'(n_pat), 8);
    chk("sat_str", s_pack, 32'h1d1e1f20);
    chk("sat_pat", p_pack, 32'h84858687);
    chk("sat_done_cyc", 32'(done_cyc), 43);
    chk("sat_index", 32'(res_index), 31);
    chk("sat_match", 32'(res_match), 1);

    // Move rr to 1 via an empty-slot0 error, then reset during SEND_PAT.
    tick();
    req = 2'b01;
    serve(0, 1'b0, 5'd0);
    chk("pre_rst_err", 32'(res_err), 1);
    tick();
    wpat(2'd0, "a"); wpat(2'd0, "b");
    req = 2'b01;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (eng_ispattern) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_send_pat", 32'(found), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 2'b00;
    chk("mid_rst_isstring", 32'(eng_isstring), 0);
    chk("mid_rst_ispattern", 32'(eng_ispattern), 0);
    chk("mid_rst_chardata", 32'(eng_chardata), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_res_err", 32'(res_err), 0);
    chk("mid_rst_str_len", 32'(str_len), 0);
    chk("mid_rst_ready", 32'(str_ready), 1);
    tick();
    chk("mid_rst_idle_hold", 32'(eng_ispattern), 0);

    // After reset: rr back to 0 and slot0 length back to 0.
    wstr("a"); wpat(2'd0, "m"); wpat(2'd1, "n");
    req = 2'b11;
    serve(1, 1'b1, 5'd0);
    chk("post_rst_rr", 32'(done_val), 1);
    chk("post_rst_npat", 32'(n_pat), 1);
    chk("post_rst_pat", p_pack, 32'h0000006d);
    chk("post_rst_done_cyc", 32'(done_cyc), 4);

    req = 2'b00;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
